cordic_iter_ctrl: RTL and testbench

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

---
 rtl/cordic_iter_ctrl.sv | 130 +++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: one micro-rotation per clock in rotation or vector mode,
// with an IDLE/ITER/DONE valid-ready handshake around a single working register set.
module cordic_iter_ctrl #(
   parameter int unsigned ITERS = 16,
   parameter int unsigned MODE  = 0
) (
   input  logic               clk,
   input  logic               RST_N,
   input  logic               soft_clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_x,
   input  logic signed [31:0] in_y,
   input  logic signed [31:0] in_angle,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] out_x,
   output logic signed [31:0] out_y,
   output logic signed [31:0] out_angle,
   output logic               busy,
   output logic [4:0]         iter_cnt
);

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   // round(atan(2^-i) * 2^31 / pi), full turn = 2^32
   localparam logic [31:0] AtanTable [32] = '{
      32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
      32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
      32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
      32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
      32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
      32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
      32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
      32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
   };

   localparam logic [4:0] LastIdx = 5'(ITERS - 1);

   state_e             state_q, state_d;
   logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [31:0] x_sh, y_sh;
   logic [31:0]        atan_i;
   logic [4:0]         cnt_q, cnt_d;
   logic               add_y_to_x;

   assign x_sh   = x_q >>> cnt_q;
   assign y_sh   = y_q >>> cnt_q;
   assign atan_i = AtanTable[cnt_q];

   // Rotation mode drives z toward 0; vector mode drives y toward 0.
   assign add_y_to_x = (MODE == 0) ? z_q[31] : ~y_q[31];

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         cnt_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         z_q   <= z_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      if (soft_clr) begin
         // Abort keeps the working registers untouched.
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  x_d     = in_x;
                  y_d     = in_y;
                  z_d     = in_angle;
                  cnt_d   = '0;
                  state_d = StIter;
               end
            end
            StIter: begin
               if (add_y_to_x) begin
                  x_d = x_q + y_sh;
                  y_d = y_q - x_sh;
                  z_d = z_q + $signed(atan_i);
               end else begin
                  x_d = x_q - y_sh;
                  y_d = y_q + x_sh;
                  z_d = z_q - $signed(atan_i);
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LastIdx) begin
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign iter_cnt  = cnt_q;
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_angle = z_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: rotation and vector instances share stimulus and are checked
// against a real-math-derived CORDIC reference plus accuracy, timing and abort/reset cases.
module tb_cordic_iter_ctrl;

   localparam int ITERS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        soft_clr, in_valid, out_ready;
   logic [31:0] in_x, in_y, in_angle;

   logic        in_ready0, out_valid0, busy0;
   logic        in_ready1, out_valid1, busy1;
   logic [4:0]  iter_cnt0, iter_cnt1;
   logic [31:0] ox0, oy0, oa0, ox1, oy1, oa1;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_acc = 0;
   bit prev_fast = 1'b0;
   int atan_tab[32];

   always #5 clk = ~clk;

   cordic_iter_ctrl #(.ITERS(ITERS), .MODE(0)) u_rot (
      .clk(clk), .RST_N(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
      .in_ready(in_ready0), .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
      .out_valid(out_valid0), .out_ready(out_ready), .out_x(ox0), .out_y(oy0),
      .out_angle(oa0), .busy(busy0), .iter_cnt(iter_cnt0)
   );

   cordic_iter_ctrl #(.ITERS(ITERS), .MODE(1)) u_vec (
      .clk(clk), .RST_N(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
      .in_ready(in_ready1), .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
      .out_valid(out_valid1), .out_ready(out_ready), .out_x(ox1), .out_y(oy1),
      .out_angle(oa1), .busy(busy1), .iter_cnt(iter_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input logic [31:0] obs, input longint ref_v,
                            input longint tol);
      longint d;
      d = longint'($signed(obs)) - ref_v;
      if (d < 0) d = -d;
      n_assert++;
      assert (d <= tol) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, $signed(obs), ref_v, tol);
      end
   endtask

   // Reference: the micro-rotation rules applied ITERS times on plain 32-bit ints.
   function automatic void model(input int mode, input int xi, input int yi, input int zi,
                                 output int xo, output int yo, output int zo);
      int x, y, z, xs, ys;
      bit pos;
      x = xi; y = yi; z = zi;
      for (int i = 0; i < ITERS; i++) begin
         xs  = x >>> i;
         ys  = y >>> i;
         pos = (mode == 0) ? (z < 0) : (y >= 0);
         if (pos) begin
            x = x + ys; y = y - xs; z = z + atan_tab[i];
         end else begin
            x = x - ys; y = y + xs; z = z - atan_tab[i];
         end
      end
      xo = x; yo = y; zo = z;
   endfunction

   task automatic run_op(input int xv, input int yv, input int av, input int hold);
      int ex0, ey0, ez0, ex1, ey1, ez1, lat;
      model(0, xv, yv, av, ex0, ey0, ez0);
      model(1, xv, yv, av, ex1, ey1, ez1);
      in_x = xv; in_y = yv; in_angle = av; in_valid = 1'b1;
      check("in_ready_idle0", 32'(in_ready0), 32'd1);
      check("in_ready_idle1", 32'(in_ready1), 32'd1);
      tick();
      in_valid = 1'b0;
      if (prev_fast) check("throughput", cyc - last_acc, ITERS + 2);
      last_acc = cyc;
      check("busy_iter", 32'(busy0), 32'd1);
      check("iter_cnt_start", 32'(iter_cnt0), 32'd0);
      check("in_ready_iter", 32'(in_ready0), 32'd0);
      lat = 0;
      while (!out_valid0 && lat < ITERS + 4) begin
         tick();
         lat++;
      end
      check("latency", lat, ITERS);
      check("out_valid1", 32'(out_valid1), 32'd1);
      check("iter_cnt_done", 32'(iter_cnt0), ITERS);
      check("rot_x", ox0, ex0);
      check("rot_y", oy0, ey0);
      check("rot_z", oa0, ez0);
      check("vec_x", ox1, ex1);
      check("vec_y", oy1, ey1);
      check("vec_z", oa1, ez1);
      for (int h = 0; h < hold; h++) begin
         // Offered operand must be ignored while a result is pending.
         in_x = ~xv; in_angle = ~av; in_valid = 1'b1;
         tick();
         check("hold_valid", 32'(out_valid0), 32'd1);
         check("hold_ready", 32'(in_ready0), 32'd0);
         check("hold_x", ox0, ex0);
         check("hold_z", oa1, ez1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("post_valid", 32'(out_valid0), 32'd0);
      check("post_ready", 32'(in_ready0), 32'd1);
      check("post_busy0", 32'(busy0), 32'd0);
      check("post_busy1", 32'(busy1), 32'd0);
      prev_fast = (hold == 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int xv, yv, av;
      for (int i = 0; i < 32; i++) begin
         atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** 31) / 3.14159265358979323846
                            + 0.5);
      end
      soft_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_x = '0; in_y = '0; in_angle = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_iter_cnt", 32'(iter_cnt0), 32'd0);
      check("rst_out_x", ox0, 32'd0);
      check("rst_out_angle", oa1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready0), 32'd1);

      // Accuracy vectors
      run_op(1000000, 0, 0, 0);
      check_tol("acc0_x", ox0, 1646760, 32);
      check_tol("acc0_y", oy0, 0, 64);
      check_tol("acc0_z", oa0, 0, 32'h10000);
      run_op(1000000, 0, 32'h2000_0000, 0);
      check_tol("acc45_x", ox0, 1164440, 64);
      check_tol("acc45_y", oy0, 1164440, 64);
      // Vector mode with ten cycles of back-pressure
      run_op(1000000, 1000000, 0, 10);
      check_tol("vec_angle", oa1, 32'h2000_0000, 32'h10000);
      check_tol("vec_mag", ox1, 2328890, 64);
      check_tol("vec_y0", oy1, 0, 64);
      run_op(-700000, 400000, -32'sh3000_0000, 0);

      // Abort at step 5 with a new operand offered in the same cycle
      in_x = 300000; in_y = -200000; in_angle = 32'h1000_0000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("clr_at_step", 32'(iter_cnt0), 32'd5);
      soft_clr = 1'b1; in_valid = 1'b1;
      tick();
      soft_clr = 1'b0; in_valid = 1'b0;
      check("clr_idle", 32'(in_ready0), 32'd1);
      check("clr_busy", 32'(busy0), 32'd0);
      check("clr_iter_cnt", 32'(iter_cnt0), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < ITERS + 2; k++) begin
         seen |= out_valid0 | out_valid1;
         tick();
      end
      check("clr_no_valid", 32'(seen), 32'd0);
      prev_fast = 1'b0;
      run_op(250000, 120000, 32'h0800_0000, 0);

      // Reset during step 8
      in_x = 500000; in_y = 500000; in_angle = -32'sh1000_0000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      check("rstmid_step", 32'(iter_cnt0), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_busy", 32'(busy0), 32'd0);
      check("rstmid_iter_cnt", 32'(iter_cnt0), 32'd0);
      check("rstmid_valid", 32'(out_valid1), 32'd0);
      check("rstmid_x", ox0, 32'd0);
      check("rstmid_y", oy1, 32'd0);
      check("rstmid_z", oa0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rstmid_ready", 32'(in_ready0), 32'd1);
      prev_fast = 1'b0;
      run_op(800000, -300000, 32'h2800_0000, 0);

      // Random operands
      for (int n = 0; n < 10; n++) begin
         xv = int'($urandom_range(4194304, 0)) - 2097152;
         yv = int'($urandom_range(4194304, 0)) - 2097152;
         av = int'($urandom_range(32'h8000_0000, 0) - 32'h4000_0000);
         run_op(xv, yv, av, int'($urandom_range(2, 0)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
